// File: rtl/alu_issue_ctrl_pkg.sv
// ============================================================================
// Module      : alu_issue_pkg
// Description : Shared opcodes, ALU function codes and FSM state type for the
//               ALU issue controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_issue_pkg;

    // RV32I opcodes handled by the issue controller
    localparam logic [6:0] OP_ALU_R = 7'b0110011;
    localparam logic [6:0] OP_ALU_I = 7'b0010011;

    // Funct3 encodings, identical to the alu_top operation select
    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SRL  = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    // Shift operations take only the low five bits of the shift amount
    function automatic logic is_shift(input logic [2:0] f3);
        return (f3 == F3_SLL) || (f3 == F3_SRL);
    endfunction

    // Compare operations update only bit 0 of the ALU result
    function automatic logic is_compare(input logic [2:0] f3);
        return (f3 == F3_SLT) || (f3 == F3_SLTU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_issue_ctrl_if.sv
// ============================================================================
// Module      : alu_issue_ctrl_if
// Description : Instruction handshake, ALU operand/result bus and retirement
//               report of the ALU issue controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_issue_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             instr_valid;
    logic             instr_ready;
    logic [31:0]      instr;
    logic [WIDTH:0]   alu_rs1;
    logic [WIDTH:0]   alu_rs2;
    logic [2:0]       alu_funct3;
    logic             alu_funct7;
    logic [WIDTH:0]   alu_rd;
    logic             retire_valid;
    logic [4:0]       retire_rd;
    logic [WIDTH-1:0] retire_data;
    logic             illegal;

    // Fetch / ALU environment side
    modport master (
        output instr_valid, instr, alu_rd,
        input  instr_ready, alu_rs1, alu_rs2, alu_funct3, alu_funct7,
        input  retire_valid, retire_rd, retire_data, illegal
    );

    // Issue controller side
    modport slave (
        input  instr_valid, instr, alu_rd,
        output instr_ready, alu_rs1, alu_rs2, alu_funct3, alu_funct7,
        output retire_valid, retire_rd, retire_data, illegal
    );
endinterface

`default_nettype wire

// File: rtl/alu_issue_regfile.sv
// ============================================================================
// Module      : alu_issue_regfile
// Description : NREGS x WIDTH architectural register file, two combinational
//               read ports, one debug read port, one write port; x0 is never
//               written so it always reads zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_regfile #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [4:0]       raddr_a,
    output logic      [WIDTH-1:0] rdata_a,
    input  wire logic [4:0]       raddr_b,
    output logic      [WIDTH-1:0] rdata_b,
    input  wire logic [4:0]       dbg_raddr,
    output logic      [WIDTH-1:0] dbg_rdata,
    input  wire logic             wr_en,
    input  wire logic [4:0]       wr_addr,
    input  wire logic [WIDTH-1:0] wr_data
);

    logic [WIDTH-1:0] regs [NREGS];

    // Clear every entry on reset; otherwise write any register except x0
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != 5'd0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rdata_a   = regs[raddr_a];
    assign rdata_b   = regs[raddr_b];
    assign dbg_rdata = regs[dbg_raddr];

endmodule

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Decodes one RV32I ALU instruction at a time, drives operands
//               to the registered alu_top, and writes back/retires the result
//               (IDLE -> EXEC -> WB, one instruction per three cycles).
//               Optional macro ALU_ISSUE_IMM_EN enables I-type (0010011).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    alu_issue_ctrl_if.slave       bus,
    input  wire logic [4:0]       dbg_raddr,
    output logic      [WIDTH-1:0] dbg_rdata
);

    state_t state;
    state_t state_nxt;

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [4:0]       rs1_idx;
    logic [4:0]       rs2_idx;
    logic             accept;
    logic             legal;
    logic [WIDTH-1:0] x_rs1;
    logic [WIDTH-1:0] x_rs2;
    logic [WIDTH-1:0] op_first;
    logic [WIDTH-1:0] op_second;

    logic [WIDTH-1:0] held_first;
    logic [WIDTH-1:0] held_second;
    logic [2:0]       held_funct3;
    logic             held_funct7;
    logic [4:0]       held_rd;
    logic             illegal_pulse;

    logic             wr_en;
    logic             unused_rd_msb;

    assign opcode  = bus.instr[6:0];
    assign funct3  = bus.instr[14:12];
    assign funct7  = bus.instr[31:25];
    assign rs1_idx = bus.instr[19:15];
    assign rs2_idx = bus.instr[24:20];
    assign accept  = bus.instr_valid && bus.instr_ready;

    // Bit WIDTH of the ALU result is never architecturally visible
    assign unused_rd_msb = bus.alu_rd[WIDTH];

    alu_issue_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .raddr_a   (rs1_idx),
        .rdata_a   (x_rs1),
        .raddr_b   (rs2_idx),
        .rdata_b   (x_rs2),
        .dbg_raddr (dbg_raddr),
        .dbg_rdata (dbg_rdata),
        .wr_en     (wr_en),
        .wr_addr   (held_rd),
        .wr_data   (bus.retire_data)
    );

    // Legality: funct7 must be zero wherever alu_top would need it (SUB/SRA)
    always_comb begin
        legal = 1'b0;
        if (opcode == OP_ALU_R) begin
            legal = (funct7 == 7'd0);
        end
`ifdef ALU_ISSUE_IMM_EN
        else if (opcode == OP_ALU_I) begin
            legal = !is_shift(funct3) || (funct7 == 7'd0);
        end
`endif
    end

    // Operand shaping: alu_top computes RS2 op RS1, so x[rs1] goes to RS2
    always_comb begin
        op_first  = x_rs1;
        op_second = x_rs2;
`ifdef ALU_ISSUE_IMM_EN
        if (opcode == OP_ALU_I) begin
            op_second = {{(WIDTH-12){bus.instr[31]}}, bus.instr[31:20]};
        end
`endif
        if (is_shift(funct3)) begin
            op_second = {{(WIDTH-5){1'b0}}, op_second[4:0]};
        end
        // Flipping both sign bits turns the unsigned compare into a signed one
        if (funct3 == F3_SLT) begin
            op_first[WIDTH-1]  = ~op_first[WIDTH-1];
            op_second[WIDTH-1] = ~op_second[WIDTH-1];
        end
    end

    // Latch the decoded instruction on acceptance and flag illegal ones
    always_ff @(posedge clk) begin
        if (!rst) begin
            held_first    <= '0;
            held_second   <= '0;
            held_funct3   <= 3'd0;
            held_funct7   <= 1'b0;
            held_rd       <= 5'd0;
            illegal_pulse <= 1'b0;
        end else begin
            illegal_pulse <= accept && !legal;
            if (accept && legal) begin
                held_first  <= op_first;
                held_second <= op_second;
                held_funct3 <= funct3;
                held_funct7 <= bus.instr[30];
                held_rd     <= bus.instr[11:7];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && legal) state_nxt = EXEC;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: handshake, retirement and write-back enable
    always_comb begin
        bus.instr_ready  = rst && (state == IDLE);
        bus.retire_valid = 1'b0;
        bus.retire_rd    = 5'd0;
        bus.retire_data  = '0;
        wr_en            = 1'b0;
        if (rst && (state == WB)) begin
            bus.retire_valid = 1'b1;
            bus.retire_rd    = held_rd;
            wr_en            = 1'b1;
            if (is_compare(held_funct3)) begin
                bus.retire_data = {{(WIDTH-1){1'b0}}, bus.alu_rd[0]};
            end else begin
                bus.retire_data = bus.alu_rd[WIDTH-1:0];
            end
        end
    end

    assign bus.alu_rs1    = {1'b0, held_second};
    assign bus.alu_rs2    = {1'b0, held_first};
    assign bus.alu_funct3 = held_funct3;
    assign bus.alu_funct7 = held_funct7;
    assign bus.illegal    = illegal_pulse;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// ============================================================================
// Module      : tb_alu_issue_ctrl
// Description : Self-checking bench for alu_issue_ctrl with a behavioural
//               registered ALU, vector table and retirement scoreboard.
//               Expectations follow ALU_ISSUE_IMM_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_ctrl;

    localparam int WIDTH = 32;

    typedef struct {
        logic [31:0] ins;
        logic        ill;
        logic [4:0]  rd;
        logic [31:0] data;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          acc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [4:0]       dbg_raddr = 5'd0;
    logic [WIDTH-1:0] dbg_rdata;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sbq[$];
    exp_t mon_e;
    vec_t vecs[$];

    alu_issue_ctrl_if #(.WIDTH(WIDTH)) bus ();

    alu_issue_ctrl #(
        .WIDTH (WIDTH),
        .NREGS (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_raddr (dbg_raddr),
        .dbg_rdata (dbg_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural registered ALU: RD <= RS2 op RS1, compares touch bit 0 only
    always @(posedge clk) begin
        case (bus.alu_funct3)
            3'd0:    bus.alu_rd <= bus.alu_rs2 + bus.alu_rs1;
            3'd1:    bus.alu_rd <= bus.alu_rs2 << bus.alu_rs1;
            3'd2,
            3'd3:    bus.alu_rd[0] <= (bus.alu_rs2 < bus.alu_rs1);
            3'd4:    bus.alu_rd <= bus.alu_rs2 ^ bus.alu_rs1;
            3'd5:    bus.alu_rd <= bus.alu_rs2 >> bus.alu_rs1;
            3'd6:    bus.alu_rd <= bus.alu_rs2 | bus.alu_rs1;
            default: bus.alu_rd <= bus.alu_rs2 & bus.alu_rs1;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every retirement must match the oldest expected entry
    always @(negedge clk) begin
        if (bus.retire_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_retire: got rd=%0d data=0x%0h expected no retire",
                         bus.retire_rd, bus.retire_data);
            end else begin
                mon_e = sbq.pop_front();
                chk("retire_rd", 64'(bus.retire_rd), 64'(mon_e.rd));
                chk("retire_data", 64'(bus.retire_data), 64'(mon_e.data));
                chk("retire_latency", 64'(cyc - mon_e.acc), 64'd1);
            end
        end
    end

    task automatic issue(input logic [31:0] ins, input logic exp_ill,
                         input logic [4:0] erd, input logic [31:0] edata,
                         input logic chk_ops = 1'b0,
                         input logic [WIDTH:0] ers2 = '0,
                         input logic [WIDTH:0] ers1 = '0);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!bus.instr_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!bus.instr_ready) begin
            chk("ready_timeout", 64'(bus.instr_ready), 64'd1);
            return;
        end
        bus.instr_valid = 1'b1;
        bus.instr       = ins;
        if (!exp_ill) begin
            e.rd   = erd;
            e.data = edata;
            e.acc  = cyc + 1;
            sbq.push_back(e);
        end
        @(negedge clk);
        bus.instr_valid = 1'b0;
        chk("illegal_pulse", 64'(bus.illegal), 64'(exp_ill));
        if (exp_ill) begin
            chk("ready_after_illegal", 64'(bus.instr_ready), 64'd1);
            @(negedge clk);
            chk("illegal_width", 64'(bus.illegal), 64'd0);
        end else begin
            chk("exec_ready", 64'(bus.instr_ready), 64'd0);
            chk("exec_funct_msb", {59'd0, bus.alu_funct3, bus.alu_rs2[WIDTH], bus.alu_rs1[WIDTH]},
                {59'd0, ins[14:12], 2'b00});
            if (chk_ops) begin
                chk("exec_alu_rs2", 64'(bus.alu_rs2), 64'(ers2));
                chk("exec_alu_rs1", 64'(bus.alu_rs1), 64'(ers1));
                chk("exec_alu_funct7", 64'(bus.alu_funct7), 64'd0);
            end
            n = 0;
            while (sbq.size() != 0 && n < 10) begin
                @(negedge clk);
                n++;
            end
            if (sbq.size() != 0) begin
                chk("retire_timeout", 64'(sbq.size()), 64'd0);
                sbq.delete();
            end
        end
    endtask

    task automatic dbg_chk(input string name, input logic [4:0] addr, input logic [31:0] exp);
        dbg_raddr = addr;
        #1;
        chk(name, 64'(dbg_rdata), 64'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         accepts;
        int         bad;
        exp_t       e;
        logic [31:0] ins;

`ifdef ALU_ISSUE_IMM_EN
        vecs.push_back('{32'h00500093, 1'b0, 5'd1, 32'd5});          // ADDI x1,x0,5
        vecs.push_back('{32'h00108133, 1'b0, 5'd2, 32'd10});         // ADD  x2,x1,x1
        vecs.push_back('{32'h02500213, 1'b0, 5'd4, 32'd37});         // ADDI x4,x0,37
        vecs.push_back('{32'h004112B3, 1'b0, 5'd5, 32'd320});        // SLL  x5,x2,x4
        vecs.push_back('{32'h0020A333, 1'b0, 5'd6, 32'd1});          // SLT  x6,x1,x2
        vecs.push_back('{32'hFFF00093, 1'b0, 5'd1, 32'hFFFFFFFF});   // ADDI x1,x0,-1
        vecs.push_back('{32'h0020A333, 1'b0, 5'd6, 32'd1});          // SLT  -1 < 10
        vecs.push_back('{32'h0020B333, 1'b0, 5'd6, 32'd0});          // SLTU
        vecs.push_back('{32'h40000033, 1'b1, 5'd0, 32'd0});          // SUB
        vecs.push_back('{32'h00700013, 1'b0, 5'd0, 32'd7});          // ADDI x0,x0,7
        vecs.push_back('{32'h4010D093, 1'b1, 5'd0, 32'd0});          // SRAI
        vecs.push_back('{32'h0000A083, 1'b1, 5'd0, 32'd0});          // LW
        vecs.push_back('{32'h0040D3B3, 1'b0, 5'd7, 32'h07FFFFFF});   // SRL  x7,x1,x4
        vecs.push_back('{32'h0F00C413, 1'b0, 5'd8, 32'hFFFFFF0F});   // XORI x8,x1,0xF0
        vecs.push_back('{32'h007474B3, 1'b0, 5'd9, 32'h07FFFF0F});   // AND  x9,x8,x7
        vecs.push_back('{32'h02109093, 1'b1, 5'd0, 32'd0});          // SLLI bad imm
`else
        vecs.push_back('{32'h00500093, 1'b1, 5'd0, 32'd0});          // ADDI
        vecs.push_back('{32'h00108133, 1'b0, 5'd2, 32'd0});          // ADD  x2,x1,x1
        vecs.push_back('{32'h40000033, 1'b1, 5'd0, 32'd0});          // SUB
        vecs.push_back('{32'h0020A333, 1'b0, 5'd6, 32'd0});          // SLT
        vecs.push_back('{32'h0020B333, 1'b0, 5'd6, 32'd0});          // SLTU
        vecs.push_back('{32'h004112B3, 1'b0, 5'd5, 32'd0});          // SLL
        vecs.push_back('{32'h0000A083, 1'b1, 5'd0, 32'd0});          // LW
        vecs.push_back('{32'h00700013, 1'b1, 5'd0, 32'd0});          // ADDI x0
        vecs.push_back('{32'h007474B3, 1'b0, 5'd9, 32'd0});          // AND
        vecs.push_back('{32'h4010D093, 1'b1, 5'd0, 32'd0});          // SRAI
        vecs.push_back('{32'h00000033, 1'b0, 5'd0, 32'd0});          // ADD x0
`endif

        // Reset state
        rst             = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 64'(bus.instr_ready), 64'd0);
        chk("reset_retire", 64'(bus.retire_valid), 64'd0);
        chk("reset_illegal", 64'(bus.illegal), 64'd0);
        chk("reset_alu_bus", {28'd0, bus.alu_funct3, bus.alu_funct7},
            {28'd0, 3'd0, 1'b0});
        chk("reset_alu_ops", 64'(bus.alu_rs1 | bus.alu_rs2), 64'd0);
        rst = 1'b1;
        #1;
        chk("ready_after_reset", 64'(bus.instr_ready), 64'd1);

        // Vector table
        foreach (vecs[i]) begin
            issue(vecs[i].ins, vecs[i].ill, vecs[i].rd, vecs[i].data);
        end

        // Operand mapping: SLT sign flip and, with immediates, sign extension
        @(negedge clk);
`ifdef ALU_ISSUE_IMM_EN
        issue(32'h0020A333, 1'b0, 5'd6, 32'd1, 1'b1, {1'b0, 32'h7FFFFFFF}, {1'b0, 32'h8000000A});
        issue(32'hFFE10613, 1'b0, 5'd12, 32'd8, 1'b1, {1'b0, 32'd10}, {1'b0, 32'hFFFFFFFE});
        issue(32'h004112B3, 1'b0, 5'd5, 32'd320, 1'b1, {1'b0, 32'd10}, {1'b0, 32'd5});
        dbg_chk("dbg_x1", 5'd1, 32'hFFFFFFFF);
        dbg_chk("dbg_x5", 5'd5, 32'd320);
        dbg_chk("dbg_x6", 5'd6, 32'd1);
        dbg_chk("dbg_x9", 5'd9, 32'h07FFFF0F);
`else
        issue(32'h0020A333, 1'b0, 5'd6, 32'd0, 1'b1, {1'b0, 32'h80000000}, {1'b0, 32'h80000000});
        dbg_chk("dbg_x6", 5'd6, 32'd0);
`endif
        dbg_chk("dbg_x0", 5'd0, 32'd0);

        // Continuous instr_valid: one acceptance per three cycles
        bus.instr = 32'h000001B3;   // ADD x3,x0,x0
        @(negedge clk);
        bus.instr_valid = 1'b1;
        accepts = 0;
        bad     = 0;
        for (int i = 0; i < 9; i++) begin
            if (bus.instr_ready !== ((i % 3) == 0)) bad++;
            if (bus.instr_ready) begin
                accepts++;
                e.rd   = 5'd3;
                e.data = 32'd0;
                e.acc  = cyc + 1;
                sbq.push_back(e);
            end
            @(negedge clk);
        end
        bus.instr_valid = 1'b0;
        chk("ready_pattern_errors", 64'(bad), 64'd0);
        chk("accept_count", 64'(accepts), 64'd3);
        repeat (4) @(negedge clk);
        chk("handshake_drain", 64'(sbq.size()), 64'd0);

        // Reset during EXEC drops the instruction
`ifdef ALU_ISSUE_IMM_EN
        ins = 32'h00500093;         // ADDI x1,x0,5
`else
        ins = 32'h000000B3;         // ADD x1,x0,x0
`endif
        chk("pre_reset_ready", 64'(bus.instr_ready), 64'd1);
        bus.instr_valid = 1'b1;
        bus.instr       = ins;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        chk("midop_exec_ready", 64'(bus.instr_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midop_reset_ready", 64'(bus.instr_ready), 64'd0);
        chk("midop_reset_retire", 64'(bus.retire_valid), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 64'(bus.instr_ready), 64'd1);
        dbg_chk("dbg_x1_after_reset", 5'd1, 32'd0);
        dbg_chk("dbg_x6_after_reset", 5'd6, 32'd0);
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
